// File: rtl/ray_dir_gen_if.sv
// ray_dir_gen_if: ray stream from ray_dir_gen to the downstream DDA/raycaster stage.
// master drives the ray payload and valid; slave returns ready.
interface ray_dir_gen_if #(
    parameter int unsigned SCREEN_W = 320
);
    localparam int unsigned ColW = $clog2(SCREEN_W);

    logic            ray_valid;
    logic            ray_ready;
    logic [ColW-1:0] ray_col;
    logic [15:0]     rayDirX;
    logic [15:0]     rayDirY;
    logic [15:0]     ray_posX;
    logic [15:0]     ray_posY;

    modport master (
        output ray_valid, ray_col, rayDirX, rayDirY, ray_posX, ray_posY,
        input  ray_ready
    );

    modport slave (
        input  ray_valid, ray_col, rayDirX, rayDirY, ray_posX, ray_posY,
        output ray_ready
    );
endinterface

// File: rtl/ray_dir_gen.sv
// ray_dir_gen: snapshots camera state on frame_switch and streams rayDir = dir + plane*cameraX
// for each column. Optional `RAY_OVERRUN_CNT_EN adds overrun_cnt for dropped frame_switch pulses.
module ray_dir_gen #(
    parameter int unsigned SCREEN_W = 320,
    parameter int          CAM_STEP = (2 ** 17) / int'(SCREEN_W)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                frame_switch,
    input  logic signed [15:0]  posX,
    input  logic signed [15:0]  posY,
    input  logic signed [15:0]  dirX,
    input  logic signed [15:0]  dirY,
    input  logic signed [15:0]  planeX,
    input  logic signed [15:0]  planeY,
    ray_dir_gen_if.master       ray,
    output logic                frame_busy,
    output logic                frame_done
`ifdef RAY_OVERRUN_CNT_EN
    ,
    output logic [7:0]          overrun_cnt
`endif
);
    localparam int unsigned ColW = $clog2(SCREEN_W);
    localparam logic [ColW-1:0]     LastCol  = ColW'(SCREEN_W - 1);
    localparam logic signed [17:0]  CamStep  = 18'(CAM_STEP);
    localparam logic signed [17:0]  CamStart = -18'sd65536;

    typedef enum logic [1:0] {StIdle, StMul, StAdd, StOut} state_e;

    state_e                 state_q;
    logic signed [15:0]     dir_x_q, dir_y_q, plane_x_q, plane_y_q;
    logic signed [17:0]     cam_q;
    logic [ColW-1:0]        col_q;
    logic signed [33:0]     prod_x_q, prod_y_q;
    logic signed [33:0]     plane_x_ext, plane_y_ext, cam_ext;

    // Full-width operands so the signed product is formed at 34 bits.
    always_comb begin
        plane_x_ext = {{18{plane_x_q[15]}}, plane_x_q};
        plane_y_ext = {{18{plane_y_q[15]}}, plane_y_q};
        cam_ext     = {{16{cam_q[17]}}, cam_q};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            dir_x_q      <= '0;
            dir_y_q      <= '0;
            plane_x_q    <= '0;
            plane_y_q    <= '0;
            cam_q        <= '0;
            col_q        <= '0;
            prod_x_q     <= '0;
            prod_y_q     <= '0;
            ray.ray_valid <= 1'b0;
            ray.ray_col  <= '0;
            ray.rayDirX  <= '0;
            ray.rayDirY  <= '0;
            ray.ray_posX <= '0;
            ray.ray_posY <= '0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
`ifdef RAY_OVERRUN_CNT_EN
            overrun_cnt  <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef RAY_OVERRUN_CNT_EN
            if (frame_switch && (state_q != StIdle) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
`endif
            unique case (state_q)
                StIdle: begin
                    if (frame_switch) begin
                        dir_x_q      <= dirX;
                        dir_y_q      <= dirY;
                        plane_x_q    <= planeX;
                        plane_y_q    <= planeY;
                        ray.ray_posX <= posX;
                        ray.ray_posY <= posY;
                        cam_q        <= CamStart;
                        col_q        <= '0;
                        frame_busy   <= 1'b1;
                        state_q      <= StMul;
                    end
                end
                StMul: begin
                    prod_x_q <= plane_x_ext * cam_ext;
                    prod_y_q <= plane_y_ext * cam_ext;
                    state_q  <= StAdd;
                end
                StAdd: begin
                    // Arithmetic >>> 16 then truncate == prod[31:16]; sum wraps mod 2^16.
                    ray.rayDirX   <= dir_x_q + 16'(prod_x_q >>> 16);
                    ray.rayDirY   <= dir_y_q + 16'(prod_y_q >>> 16);
                    ray.ray_col   <= col_q;
                    ray.ray_valid <= 1'b1;
                    state_q       <= StOut;
                end
                StOut: begin
                    if (ray.ray_valid && ray.ray_ready) begin
                        ray.ray_valid <= 1'b0;
                        if (col_q == LastCol) begin
                            frame_busy <= 1'b0;
                            frame_done <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            col_q   <= col_q + ColW'(1);
                            cam_q   <= cam_q + CamStep;
                            state_q <= StMul;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ray_dir_gen.sv
// tb_ray_dir_gen: directed tests of ray_dir_gen at SCREEN_W=4 plus one full frame at SCREEN_W=320.
// Build with +define+RAY_OVERRUN_CNT_EN to also check overrun_cnt.
module tb_ray_dir_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        fs4 = 1'b0, fs320 = 1'b0;
    logic [15:0] posX, posY, dirX, dirY, planeX, planeY;
    logic        busy4, done4, busy320, done320;
`ifdef RAY_OVERRUN_CNT_EN
    logic [7:0]  ovr4, ovr320;
`endif
    int errors = 0;
    int checks = 0;

    logic [15:0] exp_y [4] = '{16'hFF58, 16'hFFAC, 16'h0000, 16'h0054};
    logic [15:0] exp_wx [4] = '{16'h0000, 16'h3F80, 16'h7F00, 16'hBE80};

    ray_dir_gen_if #(.SCREEN_W(4))   r4 ();
    ray_dir_gen_if #(.SCREEN_W(320)) r320 ();

    ray_dir_gen #(.SCREEN_W(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .frame_switch(fs4),
        .posX(posX), .posY(posY), .dirX(dirX), .dirY(dirY), .planeX(planeX), .planeY(planeY),
        .ray(r4.master), .frame_busy(busy4), .frame_done(done4)
`ifdef RAY_OVERRUN_CNT_EN
        , .overrun_cnt(ovr4)
`endif
    );

    ray_dir_gen #(.SCREEN_W(320)) dut320 (
        .clk_in(clk), .rst_n_in(rst_n), .frame_switch(fs320),
        .posX(posX), .posY(posY), .dirX(dirX), .dirY(dirY), .planeX(planeX), .planeY(planeY),
        .ray(r320.master), .frame_busy(busy320), .frame_done(done320)
`ifdef RAY_OVERRUN_CNT_EN
        , .overrun_cnt(ovr320)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until ray_valid on the 4-column DUT; n = cycles waited (capped at 20).
    task automatic wait_valid4(output int n);
        n = 0;
        while (r4.ray_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic set_basic;
        posX = 16'h1234; posY = 16'h5678;
        dirX = 16'h0100; dirY = 16'h0000;
        planeX = 16'h0000; planeY = 16'h00A8;
    endtask

    task automatic test_reset;
        set_basic();
        r4.ray_ready = 1'b1;
        r320.ray_ready = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        checks++; if (r4.ray_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", r4.ray_valid); end
        checks++; if (r4.ray_col !== 2'd0) begin errors++; $display("FAIL reset_col got %0d want 0", r4.ray_col); end
        checks++; if (r4.rayDirX !== 16'h0) begin errors++; $display("FAIL reset_dirx got %h want 0000", r4.rayDirX); end
        checks++; if (r4.rayDirY !== 16'h0) begin errors++; $display("FAIL reset_diry got %h want 0000", r4.rayDirY); end
        checks++; if (r4.ray_posX !== 16'h0) begin errors++; $display("FAIL reset_posx got %h want 0000", r4.ray_posX); end
        checks++; if (r4.ray_posY !== 16'h0) begin errors++; $display("FAIL reset_posy got %h want 0000", r4.ray_posY); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done4); end
`ifdef RAY_OVERRUN_CNT_EN
        checks++; if (ovr4 !== 8'd0) begin errors++; $display("FAIL reset_ovr got %0d want 0", ovr4); end
`endif
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int n;
        set_basic();
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy4); end
        checks++; if (r4.ray_posX !== 16'h1234) begin errors++; $display("FAIL basic_posx got %h want 1234", r4.ray_posX); end
        checks++; if (r4.ray_posY !== 16'h5678) begin errors++; $display("FAIL basic_posy got %h want 5678", r4.ray_posY); end
        checks++; if (r4.ray_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", r4.ray_valid); end
        for (int c = 0; c < 4; c++) begin
            wait_valid4(n);
            checks++; if (n != 2) begin errors++; $display("FAIL basic_latency col%0d got %0d want 2", c, n); end
            checks++; if (r4.ray_col !== 2'(c)) begin errors++; $display("FAIL basic_col got %0d want %0d", r4.ray_col, c); end
            checks++; if (r4.rayDirX !== 16'h0100) begin errors++; $display("FAIL basic_dirx col%0d got %h want 0100", c, r4.rayDirX); end
            checks++; if (r4.rayDirY !== exp_y[c]) begin errors++; $display("FAIL basic_diry col%0d got %h want %h", c, r4.rayDirY, exp_y[c]); end
            tick();
            checks++; if (r4.ray_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop col%0d got %b want 0", c, r4.ray_valid); end
        end
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy4); end
        tick();
        checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done4); end
    endtask

    task automatic test_backpressure;
        int n;
        set_basic();
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        wait_valid4(n);
        tick();
        r4.ray_ready = 1'b0;
        wait_valid4(n);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (r4.ray_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got %b want 1", i, r4.ray_valid); end
            checks++; if (r4.ray_col !== 2'd1) begin errors++; $display("FAIL bp_col cyc%0d got %0d want 1", i, r4.ray_col); end
            checks++; if (r4.rayDirY !== 16'hFFAC) begin errors++; $display("FAIL bp_diry cyc%0d got %h want FFAC", i, r4.rayDirY); end
        end
        r4.ray_ready = 1'b1;
        tick();
        checks++; if (r4.ray_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b want 0", r4.ray_valid); end
        for (int c = 2; c < 4; c++) begin
            wait_valid4(n);
            checks++; if (r4.ray_col !== 2'(c)) begin errors++; $display("FAIL bp_resume_col got %0d want %0d", r4.ray_col, c); end
            checks++; if (r4.rayDirY !== exp_y[c]) begin errors++; $display("FAIL bp_resume_diry got %h want %h", r4.rayDirY, exp_y[c]); end
            tick();
        end
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL bp_done got %b want 1", done4); end
        tick();
    endtask

    task automatic test_overrun;
        int n;
        set_basic();
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        wait_valid4(n); tick();
        wait_valid4(n); tick();
        wait_valid4(n);
        checks++; if (r4.ray_col !== 2'd2) begin errors++; $display("FAIL ovr_col2 got %0d want 2", r4.ray_col); end
        dirX = 16'h0200; planeY = 16'h0100; posX = 16'h9999; posY = 16'h1111;
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL ovr_busy got %b want 1", busy4); end
`ifdef RAY_OVERRUN_CNT_EN
        checks++; if (ovr4 !== 8'd1) begin errors++; $display("FAIL ovr_cnt1 got %0d want 1", ovr4); end
`endif
        wait_valid4(n);
        checks++; if (r4.ray_col !== 2'd3) begin errors++; $display("FAIL ovr_col3 got %0d want 3", r4.ray_col); end
        checks++; if (r4.rayDirX !== 16'h0100) begin errors++; $display("FAIL ovr_dirx got %h want 0100", r4.rayDirX); end
        checks++; if (r4.rayDirY !== 16'h0054) begin errors++; $display("FAIL ovr_diry got %h want 0054", r4.rayDirY); end
        checks++; if (r4.ray_posX !== 16'h1234) begin errors++; $display("FAIL ovr_posx got %h want 1234", r4.ray_posX); end
        checks++; if (r4.ray_posY !== 16'h5678) begin errors++; $display("FAIL ovr_posy got %h want 5678", r4.ray_posY); end
        // frame_switch on the final handshake edge must also be dropped
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL ovr_done got %b want 1", done4); end
`ifdef RAY_OVERRUN_CNT_EN
        checks++; if (ovr4 !== 8'd2) begin errors++; $display("FAIL ovr_cnt2 got %0d want 2", ovr4); end
`endif
        repeat (3) tick();
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL ovr_no_restart_busy got %b want 0", busy4); end
        checks++; if (r4.ray_valid !== 1'b0) begin errors++; $display("FAIL ovr_no_restart_valid got %b want 0", r4.ray_valid); end
    endtask

    task automatic test_wrap;
        int n;
        posX = 16'h0001; posY = 16'h0002;
        dirX = 16'h7F00; dirY = 16'h0000; planeX = 16'h7F00; planeY = 16'h0000;
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wait_valid4(n);
            checks++; if (r4.rayDirX !== exp_wx[c]) begin errors++; $display("FAIL wrap_dirx col%0d got %h want %h", c, r4.rayDirX, exp_wx[c]); end
            checks++; if (r4.rayDirY !== 16'h0000) begin errors++; $display("FAIL wrap_diry col%0d got %h want 0000", c, r4.rayDirY); end
            tick();
        end
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", done4); end
        tick();
    endtask

    task automatic test_reset_mid;
        int n;
        set_basic();
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        wait_valid4(n); tick();
        wait_valid4(n);
        checks++; if (r4.ray_col !== 2'd1) begin errors++; $display("FAIL rmid_col got %0d want 1", r4.ray_col); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (r4.ray_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", r4.ray_valid); end
        checks++; if (r4.ray_col !== 2'd0) begin errors++; $display("FAIL rmid_col0 got %0d want 0", r4.ray_col); end
        checks++; if (r4.rayDirY !== 16'h0) begin errors++; $display("FAIL rmid_diry got %h want 0000", r4.rayDirY); end
        checks++; if (r4.rayDirX !== 16'h0) begin errors++; $display("FAIL rmid_dirx got %h want 0000", r4.rayDirX); end
        checks++; if (r4.ray_posX !== 16'h0) begin errors++; $display("FAIL rmid_posx got %h want 0000", r4.ray_posX); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy4); end
        repeat (3) begin
            tick();
            checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done4); end
        end
        #2 rst_n = 1'b1;
        tick();
        fs4 = 1'b1; tick(); fs4 = 1'b0;
        wait_valid4(n);
        checks++; if (n != 2) begin errors++; $display("FAIL rmid_restart_lat got %0d want 2", n); end
        checks++; if (r4.ray_col !== 2'd0) begin errors++; $display("FAIL rmid_restart_col got %0d want 0", r4.ray_col); end
        checks++; if (r4.rayDirY !== 16'hFF58) begin errors++; $display("FAIL rmid_restart_diry got %h want FF58", r4.rayDirY); end
        for (int c = 0; c < 4; c++) begin
            wait_valid4(n);
            tick();
        end
        tick();
    endtask

    task automatic test_full320;
        int hs;
        bit seen_done;
        hs = 0;
        seen_done = 1'b0;
        fs320 = 1'b1; tick(); fs320 = 1'b0;
        for (int i = 0; i < 1400 && !seen_done; i++) begin
            if (r320.ray_valid === 1'b1) begin
                checks++; if (r320.ray_col !== 9'(hs)) begin errors++; $display("FAIL full_col got %0d want %0d", r320.ray_col, hs); end
                hs++;
            end
            tick();
            if (done320 === 1'b1) seen_done = 1'b1;
        end
        checks++; if (!seen_done) begin errors++; $display("FAIL full_done got 0 want 1 within budget"); end
        checks++; if (hs != 320) begin errors++; $display("FAIL full_handshakes got %0d want 320", hs); end
        tick();
        checks++; if (done320 !== 1'b0) begin errors++; $display("FAIL full_done_pulse got %b want 0", done320); end
        checks++; if (busy320 !== 1'b0) begin errors++; $display("FAIL full_busy got %b want 0", busy320); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_wrap();
        test_reset_mid();
        test_full320();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ray_dir_gen.md
Name: ray_dir_gen

Overview:
- Consumer of the camera state (posX/posY/dirX/dirY/planeX/planeY) that the button/movement control path publishes on frame_switch.
- On each frame_switch it snapshots the camera state. It then streams one ray direction per screen column, rayDir = dir + plane*cameraX, to the downstream DDA/raycaster over a valid/ready handshake.
- Column 0 is the left edge (cameraX = -1).

Parameters:
- SCREEN_W, 320, number of columns per frame (>=2).
- CAM_STEP, (2**17)/SCREEN_W (integer floor), cameraX increment per column, signed Q1.16.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- frame_switch  input  1  single-cycle frame-start strobe
- posX, posY  input  16  camera position, signed Q8.8
- dirX, dirY  input  16  view direction, signed Q8.8
- planeX, planeY  input  16  camera plane, signed Q8.8
- ray_ready  input  1  downstream accepts ray
- ray_valid  output  1  ray outputs valid
- ray_col  output  $clog2(SCREEN_W)  column index of current ray
- rayDirX, rayDirY  output  16  ray direction, signed Q8.8
- ray_posX, ray_posY  output  16  snapshotted position for this frame
- frame_busy  output  1  high from snapshot until last ray accepted
- frame_done  output  1  one-cycle pulse after last ray accepted

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal snapshot, cameraX and column registers 0. Reset asserted mid-frame aborts immediately; no frame_done is produced.
- States: IDLE, MUL, ADD, OUT.
- IDLE: on frame_switch=1 at an edge:
  - capture pos/dir/plane into snapshot registers; ray_posX/ray_posY update at this edge;
  - set cam = -65536 (18-bit signed Q1.16) and col = 0;
  - set frame_busy = 1 and go to MUL.
- MUL, 1 cycle:
  - register prodX = planeX_s*cam and prodY = planeY_s*cam (34-bit signed);
  - go to ADD.
- ADD, 1 cycle:
  - rayDirX <= dirX_s + prodX[31:16] and rayDirY <= dirY_s + prodY[31:16]; the slice is an arithmetic shift right by 16 (floor), and the sum wraps modulo 2^16;
  - ray_col <= col; ray_valid <= 1; go to OUT.
- Latency: first ray_valid is high in the cycle after the 3rd rising edge counting the capture edge. Per-ray turnaround is 3 cycles when ray_ready is held high.
- OUT:
  - ray_valid, ray_col, rayDirX and rayDirY hold stable until ray_valid & ray_ready at an edge;
  - on that edge, if col != SCREEN_W-1: col++, cam += CAM_STEP, ray_valid <= 0, go to MUL;
  - if col == SCREEN_W-1: ray_valid <= 0, frame_busy <= 0, frame_done <= 1 for exactly one cycle, go to IDLE.
- frame_switch while frame_busy=1 is ignored, including the cycle of the final handshake. The snapshot never changes mid-frame.
- Camera inputs are sampled only at the capture edge. Changes at any other time have no effect on the current frame.
- ray_valid never deasserts without a handshake, except on reset.

Optional Feature:
- Macro RAY_OVERRUN_CNT_EN.
- When defined:
  - adds output overrun_cnt, 8 bits, reset 0;
  - increments by 1, saturating at 255, on every frame_switch ignored because frame_busy=1.
- When undefined: the port and counter do not exist; overruns are silently dropped.

Test Plan:
- SCREEN_W=4 (CAM_STEP=32768), dir=(0x0100,0x0000), plane=(0x0000,0x00A8), ray_ready=1, pulse frame_switch:
  - col0..3 give rayDirY = 0xFF58, 0xFFAC, 0x0000, 0x0054; rayDirX = 0x0100 for all;
  - first ray_valid 3 cycles after capture; frame_done pulses once; frame_busy then 0.
- Backpressure: same setup, ray_ready=0 for 5 cycles at col1 → ray_valid stays 1, ray_col=1 and rayDirY=0xFFAC stable; the stream resumes on ready.
- Camera inputs changed and frame_switch pulsed at col2 → remaining rays use old snapshot; ray_posX unchanged; with RAY_OVERRUN_CNT_EN, overrun_cnt=1.
- Wrap: dir=(0x7F00,0), plane=(0x7F00,0), SCREEN_W=4, col3 → rayDirX = 0x7F00+0x3F80 wraps to 0xBE80.
- rst_n_in low mid-frame at col1 → all outputs 0 asynchronously; no frame_done; next frame_switch after release restarts at col0.
- Default SCREEN_W=320, ray_ready=1: exactly 320 handshakes with ray_col 0..319 in order; frame_done after handshake 320.
